// File: rtl/microcode_sequencer.sv
// microcode_sequencer
//   Issues one 32-bit control word per clock. It looks up the microcode ROM
//   at {ext, opcode, flags, step}. It advances its own micro-step counter from
//   the sequencing bits of the word it is issuing. It also offers
//   run/halt/break/single-step control to a debug front-end.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   opcode       instruction register contents (stable for an instruction)
//   flags        ALU flags {C,Z,N,V}, sampled combinationally every cycle
//   rom_addr     {ext, opcode, flags, step} to the microcode ROM
//   rom_data     microcode word, combinational read of rom_addr
//   brk_enable   when low, the break bit (27) of a word is ignored
//   resume       pulse: leave HALT (if no fault) or BREAK
//   single_step  pulse: issue exactly one word while in BREAK
//   control_word word to the field splitter (IDLE_WORD when not executing)
//   step         current micro-step
//   ext          extension page bit
//   halted       high in HALT
//   in_break     high in BREAK (not in the single-step cycle)
//   fault        sticky micro-step overrun flag, cleared only by reset
//
// Sequencing bits of the issued word w:
//   w[24] low  : step reset (step <= 0, ext <= 0), wins over w[25]
//   w[25] low  : extend onto the extension page (ext <= 1, step + 1)
//   w[26] high : halt after this word
//   w[27] high : break after this word (only when brk_enable)
module microcode_sequencer #(
  parameter int unsigned STEP_W    = 4,
  parameter int unsigned OP_W      = 8,
  parameter int unsigned FLAG_W    = 4,
  parameter logic [31:0] IDLE_WORD = 32'h0300_0000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [OP_W-1:0]               opcode,
  input  logic [FLAG_W-1:0]             flags,
  output logic [OP_W+FLAG_W+STEP_W:0]   rom_addr,
  input  logic [31:0]                   rom_data,
  input  logic                          brk_enable,
  input  logic                          resume,
  input  logic                          single_step,
  output logic [31:0]                   control_word,
  output logic [STEP_W-1:0]             step,
  output logic                          ext,
  output logic                          halted,
  output logic                          in_break,
  output logic                          fault
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HALT  = 2'd1,
    S_BREAK = 2'd2,
    S_STEP1 = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic              executing;
  logic              w_step_rst_n;
  logic              w_ext_n;
  logic              w_halt;
  logic              w_brk;
  logic              overrun;
  logic [STEP_W-1:0] step_nxt;
  logic              ext_nxt;
  logic              fault_nxt;

  // Address and word path are purely combinational so that the word for the
  // current step (and current flags) is issued in the same cycle.
  assign rom_addr     = {ext, opcode, flags, step};
  assign executing    = (state == S_RUN) || (state == S_STEP1);
  assign control_word = executing ? rom_data : IDLE_WORD;

  assign w_step_rst_n = rom_data[24];
  assign w_ext_n      = rom_data[25];
  assign w_halt       = rom_data[26];
  assign w_brk        = rom_data[27];

  // Running off the end of a page: the last step of a page may only end the
  // sequence or hop onto the extension page. Hopping again (ext already set)
  // or plain incrementing past the last step is an overrun.
  assign overrun = executing && (&step) && w_step_rst_n && (ext || w_ext_n);

  always_comb begin
    step_nxt  = step;
    ext_nxt   = ext;
    fault_nxt = fault;
    state_nxt = state;

    if (executing) begin
      if (overrun) begin
        step_nxt  = '0;
        ext_nxt   = 1'b0;
        fault_nxt = 1'b1;
      end else if (!w_step_rst_n) begin
        step_nxt = '0;
        ext_nxt  = 1'b0;
      end else if (!w_ext_n) begin
        step_nxt = step + 1'b1;
        ext_nxt  = 1'b1;
      end else begin
        step_nxt = step + 1'b1;
      end
    end

    unique case (state)
      S_RUN: begin
        if (overrun || w_halt)      state_nxt = S_HALT;
        else if (w_brk && brk_enable) state_nxt = S_BREAK;
        else                        state_nxt = S_RUN;
      end
      S_STEP1: begin
        // The break bit does not matter here: a single step always lands
        // back in BREAK unless the word halts or overruns.
        if (overrun || w_halt) state_nxt = S_HALT;
        else                   state_nxt = S_BREAK;
      end
      S_HALT: begin
        if (resume && !fault) state_nxt = S_RUN;
      end
      S_BREAK: begin
        if (resume)           state_nxt = S_RUN;
        else if (single_step) state_nxt = S_STEP1;
      end
      default: state_nxt = S_RUN;
    endcase
  end

  // halted/in_break are registered from the next state so they line up
  // exactly with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_RUN;
      step     <= '0;
      ext      <= 1'b0;
      fault    <= 1'b0;
      halted   <= 1'b0;
      in_break <= 1'b0;
    end else begin
      state    <= state_nxt;
      step     <= step_nxt;
      ext      <= ext_nxt;
      fault    <= fault_nxt;
      halted   <= (state_nxt == S_HALT);
      in_break <= (state_nxt == S_BREAK);
    end
  end

endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
- Generates the 32-bit control word each clock by indexing the microcode ROM with the extension page, opcode, flags and micro-step.
- Owns the step counter and reacts to the sequencing fields of its own control word: step reset (bit 24, active-low), step extension (bit 25, active-low), halt (bit 26) and break (bit 27).
- Provides run/halt/break/single-step control for the debug front-end.
- Sits between the instruction register and ROM on one side and the control-word field splitter on the other.

Parameters:
- STEP_W, 4, micro-step counter width; steps per page = 2**STEP_W.
- OP_W, 8, opcode width.
- FLAG_W, 4, ALU flag width (C, Z, N, V).
- IDLE_WORD, 32'h0300_0000, control word driven when not executing: all strobes inactive, active-low bits 24/25 high.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high.
- opcode, input, OP_W, current instruction register contents; stable during an instruction.
- flags, input, FLAG_W, ALU flags.
- rom_addr, output, 1+OP_W+FLAG_W+STEP_W, concatenation {ext, opcode, flags, step}.
- rom_data, input, 32, microcode word; combinational read of rom_addr.
- brk_enable, input, 1, when 0 the break bit (27) is ignored.
- resume, input, 1, single-cycle pulse: continue from HALT or BREAK.
- single_step, input, 1, single-cycle pulse: execute one micro-step while in BREAK.
- control_word, output, 32, word to the field splitter.
- step, output, STEP_W, current micro-step.
- ext, output, 1, extension page bit.
- halted, output, 1, high in HALT.
- in_break, output, 1, high in BREAK.
- fault, output, 1, sticky overrun flag.

Behaviour:
- State machine states: RUN, HALT, BREAK, STEP1.
  - "Executing" means state is RUN or STEP1.
  - control_word = rom_data while executing, otherwise IDLE_WORD. This path is combinational: zero latency from rom_data.
- Reset: state = RUN, step = 0, ext = 0, fault = 0.
  - halted = 0 and in_break = 0.
  - Reset mid-instruction or mid-break abandons everything. The next cycle fetches {0, opcode, flags, 0}.
- Step update, executing cycles only, using the current word w:
  - w[24] == 0: step <= 0 and ext <= 0. This takes priority over w[25].
  - Else w[25] == 0: ext <= 1 and step <= step + 1.
  - Else: step <= step + 1.
  - Overrun: step == all-ones, w[24] == 1, and either ext == 1 or w[25] == 1. Response: step <= 0, ext <= 0, fault <= 1, state <= HALT.
- State transitions from RUN, evaluated after the step update, so the update always happens:
  - w[26] == 1 -> HALT.
  - Else w[27] == 1 and brk_enable == 1 -> BREAK.
  - Else stay in RUN.
  - The halting or breaking word's own strobes are issued in that cycle.
- HALT:
  - step and ext hold.
  - resume with fault == 0 -> RUN.
  - With fault == 1, resume is ignored; only reset exits.
  - single_step is ignored.
- BREAK:
  - step and ext hold.
  - resume -> RUN.
  - Else single_step -> STEP1.
  - If both pulses arrive in the same cycle, resume wins.
- STEP1:
  - Exactly one word is issued and the step is updated as in RUN.
  - Next state: HALT if w[26] == 1 or on overrun; otherwise BREAK. The break bit is irrelevant here.
  - resume and single_step are ignored in STEP1.
- Outputs:
  - halted = (state == HALT).
  - in_break = (state == BREAK); STEP1 is not reported as BREAK.
- Flags are sampled combinationally every cycle. Conditional microcode therefore sees the current flags at each step.

Test Plan:
- Reset, opcode 0x12, ROM word 0x0300_0000 at steps 0..2 and 0x0200_0000 at step 3 -> rom_addr steps 0,1,2,3 then 0; control_word matches ROM; ext stays 0.
- Word at step 1 = 0x0100_0000 (ext request) -> next rom_addr has ext = 1 and step = 2; step reset later clears ext.
- Word 0x0700_0000 at step 2 -> that word appears on control_word; next cycle halted = 1, control_word = 0x0300_0000, step = 3; resume pulse -> RUN at step 3.
- brk_enable = 1, word 0x0B00_0000 -> in_break = 1, then:
  - single_step -> exactly one ROM word issued, in_break returns 1;
  - single_step and resume in the same cycle -> RUN.
  - Repeat with brk_enable = 0 -> no break.
- Every word 0x0300_0000 with ext = 0 -> after 16 steps fault = 1 and halted = 1; resume ignored; reset clears fault and returns to step 0.
- Reset asserted while in BREAK at step 5, ext = 1 -> next cycle state RUN, step 0, ext 0, in_break 0.
